// File: rtl/word_serializer.sv
// word_serializer: framed parallel-to-serial transmitter (start bit, LSB-first data, stop bit).
// Define WORD_SERIALIZER_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module word_serializer #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             data_o,
   output logic             busy_o,
   output logic             done_o
);

   // state  | meaning
   // IDLE   | line high, waiting for a word
   // START  | driving the start bit (0)
   // DATA   | driving data bits, LSB first
   // PARITY | driving the even-parity bit
   // STOP   | driving the stop bit (1)
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef WORD_SERIALIZER_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state, w_state_nxt;
   logic [TW-1:0]    r_timer, w_timer_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic             r_data, w_data_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             w_bit_end;
   logic [WIDTH-1:0] w_rot;

   assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));
   // Rotating rather than shifting keeps the word's XOR intact for the parity bit.
   assign w_rot     = (r_shift >> 1) | (r_shift << (WIDTH - 1));

   assign ready_o = (r_state == S_IDLE) && enable_i;
   assign data_o  = r_data;
   assign busy_o  = r_busy;
   assign done_o  = r_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      if (enable_i) begin
         if (r_state != S_IDLE)
            w_timer_nxt = w_bit_end ? '0 : r_timer + TW'(1);
         case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  w_shift_nxt = data_i;
                  w_state_nxt = S_START;
                  w_data_nxt  = 1'b0;
                  w_busy_nxt  = 1'b1;
                  w_timer_nxt = '0;
                  w_idx_nxt   = '0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  w_state_nxt = S_DATA;
                  w_data_nxt  = r_shift[0];
                  w_idx_nxt   = '0;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_idx == IW'(WIDTH - 1)) begin
                     w_idx_nxt   = '0;
`ifdef WORD_SERIALIZER_PARITY_EN
                     w_state_nxt = S_PARITY;
                     w_data_nxt  = ^r_shift;
`else
                     w_state_nxt = S_STOP;
                     w_data_nxt  = 1'b1;
`endif
                  end else begin
                     w_idx_nxt   = r_idx + IW'(1);
                     w_shift_nxt = w_rot;
                     w_data_nxt  = w_rot[0];
                  end
               end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  w_state_nxt = S_STOP;
                  w_data_nxt  = 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_data_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: randomized frames checked cycle by cycle against a frame-list model.
// Honours WORD_SERIALIZER_PARITY_EN when the bench and design are built with it.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int N = 10 + P;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4 = 1'b1, enable4 = 1'b1, valid4 = 1'b0;
   logic [7:0] data4 = '0;
   logic       ready4, ser4, busy4, done4;

   logic       rst1 = 1'b1, enable1 = 1'b1, valid1 = 1'b0;
   logic [7:0] data1 = '0;
   logic       ready1, ser1, busy1, done1;

   int vectors = 0;
   int miscompares = 0;

   word_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
      .clk_i(clk), .rst_i(rst4), .enable_i(enable4), .data_i(data4), .valid_i(valid4),
      .ready_o(ready4), .data_o(ser4), .busy_o(busy4), .done_o(done4));

   word_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .enable_i(enable1), .data_i(data1), .valid_i(valid1),
      .ready_o(ready1), .data_o(ser1), .busy_o(busy1), .done_o(done1));

   // Expected line values of one frame, in transmission order.
   function automatic logic [15:0] frame_bits(input logic [7:0] w);
      logic [15:0] b;
      int ones;
      b    = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         b[i+1] = ((w >> i) & 8'd1) != 0;
         ones  += int'((w >> i) & 8'd1);
      end
      if (P == 1) b[9] = (ones % 2) == 1;
      b[N-1] = 1'b1;
      return b;
   endfunction

   task automatic run_frame4(input logic [7:0] w, input int stall_at, input int stall_len,
                             input int rst_at, input string name);
      logic [15:0] bits;
      int   tot, e;
      logic en, finished;
      logic exp_d, exp_b, exp_dn, exp_r;
      bits = frame_bits(w);
      tot = N * 4;
      e = 1;
      finished = 1'b0;
      @(negedge clk);
      enable4 = 1'b1; valid4 = 1'b1; data4 = w;
      #1;
      vectors++;
      if (ready4 !== 1'b1 || busy4 !== 1'b0 || ser4 !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_idle: ready=%b busy=%b data=%b, required 1 0 1", name, ready4, busy4, ser4);
      end
      for (int c = 1; c <= tot + stall_len + 5 && !finished; c++) begin
         @(negedge clk);
         en = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
         enable4 = en;
         data4 = 8'($urandom);
         valid4 = (e <= tot) ? 1'($urandom % 2) : 1'b0;
         if (c == rst_at) rst4 = 1'b1;
         #1;
         if (e <= tot) begin
            exp_d = bits[(e-1)/4]; exp_b = 1'b1; exp_dn = 1'b0; exp_r = 1'b0;
         end else begin
            exp_d = 1'b1; exp_b = 1'b0; exp_dn = 1'b1; exp_r = en;
            finished = 1'b1;
         end
         vectors++;
         if (ser4 !== exp_d || busy4 !== exp_b || done4 !== exp_dn || ready4 !== exp_r) begin
            miscompares++;
            $display("FAIL %s_cycle%0d: data/busy/done/ready=%b%b%b%b, required %b%b%b%b",
                     name, c, ser4, busy4, done4, ready4, exp_d, exp_b, exp_dn, exp_r);
         end
         if (finished) begin
            vectors++;
            if (c != tot + 1 + stall_len) begin
               miscompares++;
               $display("FAIL %s_duration: done at cycle %0d, required %0d", name, c, tot + 1 + stall_len);
            end
         end
         if (c == rst_at) begin
            @(negedge clk);
            rst4 = 1'b0; valid4 = 1'b0; enable4 = 1'b1;
            #1;
            vectors++;
            if (ser4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || ready4 !== 1'b1) begin
               miscompares++;
               $display("FAIL %s_after_rst: data/busy/done/ready=%b%b%b%b, required 1001",
                        name, ser4, busy4, done4, ready4);
            end
            repeat (8) begin
               @(negedge clk); #1;
               vectors++;
               if (ser4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
                  miscompares++;
                  $display("FAIL %s_post_rst_idle: data/busy/done=%b%b%b, required 100", name, ser4, busy4, done4);
               end
            end
            return;
         end
         if (en) e++;
      end
      if (!finished) begin
         miscompares++;
         $display("FAIL %s_timeout: no done pulse within budget", name);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst4 = 1'b1; enable4 = 1'b1; valid4 = 1'b0;
      repeat (2) @(negedge clk);
      rst4 = 1'b0;
      #1;
      vectors++;
      if (ser4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || ready4 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: data/busy/done/ready=%b%b%b%b, required 1001", ser4, busy4, done4, ready4);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         vectors++;
         if (ser4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle%0d: data/busy/done/ready=%b%b%b%b, required 1001",
                     i, ser4, busy4, done4, ready4);
         end
      end
   endtask

   task automatic test_single_frame();
      run_frame4(8'hA5, 0, 0, 0, "single_a5");
   endtask

   task automatic test_parity();
      run_frame4(8'hA5, 0, 0, 0, "parity_a5");
      run_frame4(8'h01, 0, 0, 0, "parity_01");
   endtask

   task automatic test_random_frames();
      for (int k = 0; k < 6; k++) run_frame4(8'($urandom), 0, 0, 0, "random");
   endtask

   task automatic test_enable_stall();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         enable4 = 1'b0; valid4 = 1'b1; data4 = 8'($urandom);
         #1;
         vectors++;
         if (ready4 !== 1'b0 || busy4 !== 1'b0 || ser4 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_idle%0d: ready/busy/data=%b%b%b, required 001", i, ready4, busy4, ser4);
         end
      end
      // Data bit 3 occupies cycles 17..20 after the handshake; stall from cycle 18.
      run_frame4(8'($urandom), 18, 7, 0, "stall");
   endtask

   task automatic test_reset_mid_frame();
      // Cycle 26 lies inside data bit 5.
      run_frame4(8'($urandom), 0, 0, 26, "rst_mid");
      run_frame4(8'($urandom), 0, 0, 0, "after_rst");
   endtask

   task automatic test_back_to_back();
      logic [15:0] b1, b2;
      logic exp_d, exp_b, exp_dn, exp_r;
      b1 = frame_bits(8'h3C);
      b2 = frame_bits(8'hC3);
      @(negedge clk);
      rst1 = 1'b1; enable1 = 1'b1; valid1 = 1'b0;
      repeat (2) @(negedge clk);
      rst1 = 1'b0; valid1 = 1'b1; data1 = 8'h3C;
      #1;
      vectors++;
      if (ready1 !== 1'b1 || ser1 !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_idle: ready/data=%b%b, required 11", ready1, ser1);
      end
      for (int k = 1; k <= 2*N + 3; k++) begin
         @(negedge clk);
         if (k == 1) data1 = 8'hC3;
         if (k == 2*N + 2) valid1 = 1'b0;
         #1;
         if (k <= N) begin
            exp_d = b1[k-1]; exp_b = 1'b1; exp_dn = 1'b0; exp_r = 1'b0;
         end else if (k == N + 1 || k == 2*N + 2) begin
            exp_d = 1'b1; exp_b = 1'b0; exp_dn = 1'b1; exp_r = 1'b1;
         end else if (k <= 2*N + 1) begin
            exp_d = b2[k-N-2]; exp_b = 1'b1; exp_dn = 1'b0; exp_r = 1'b0;
         end else begin
            exp_d = 1'b1; exp_b = 1'b0; exp_dn = 1'b0; exp_r = 1'b1;
         end
         vectors++;
         if (ser1 !== exp_d || busy1 !== exp_b || done1 !== exp_dn || ready1 !== exp_r) begin
            miscompares++;
            $display("FAIL b2b_cycle%0d: data/busy/done/ready=%b%b%b%b, required %b%b%b%b",
                     k, ser1, busy1, done1, ready1, exp_d, exp_b, exp_dn, exp_r);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_random_frames();
      test_enable_stall();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
